cla_8bit_adder: RTL and testbench
=================================

// Module: cla_8bit_adder
// PURPOSE
//   8-bit unsigned carry-lookahead adder with a registered 9-bit result.
//   Carry-in is fixed at 0, so sum = a + b with the carry-out as sum[8].
//   Carries use two-level lookahead: bit propagate/generate, then 4-bit groups,
//   then a group-level lookahead unit. No ripple path between groups.
//   Used as a single-cycle arithmetic leaf in datapaths that need a fast 8-bit add.
// PARAMETERS
//   WIDTH  8  operand width; only 8 is supported. Elaboration fails for other values.
//   GROUP  4  lookahead group size; WIDTH/GROUP = 2 groups.
// PORTS
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  reset; one clock, synchronous, active-low
//   a      in   8  operand A, unsigned
//   b      in   8  operand B, unsigned
//   sum    out  9  registered a+b; sum[8] = carry-out
// BEHAVIOUR
//   - Bit level, for i = 0..7: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
//   - Group k (bits 4k..4k+3), lookahead carries with group carry-in cg:
//       c1 = g0 | p0&cg
//       c2 = g1 | p1&g0 | p1&p0&cg
//       c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&cg
//   - Group generate: G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
//   - Group propagate: P = p3&p2&p1&p0.
//   - Second level:
//       c0 = 0
//       c4 = G0
//       c8 = G1 | P1&G0
//     c4 and c8 are both formed from G/P terms. Group 1 never waits on group 0's
//     internal carries.
//   - Sum bits: s[i] = p[i] ^ c[i]; s[8] = c8.
//   - The adder core is purely combinational from a and b.
//     The only state is the 9-bit sum register.
//   - Register update at each rising clk edge:
//       rst_n == 0 : sum <= 9'd0 (reset has priority)
//       otherwise  : sum <= {c8, s[7:0]}
//   - Latency: operands sampled at edge N appear on sum just after edge N.
//     The register is written every cycle; there is no enable or handshake.
//   - Reset value: sum = 0. Reset asserted mid-stream clears sum at the next edge.
//     The first edge after deassertion loads the current a+b.
//   - Arithmetic: unsigned, no overflow possible (max 255+255 = 510 fits in 9 bits).
//   - Inputs with X/Z propagate X to sum.
//   - Results are bit-exact to a+b for all 65536 operand pairs.
// TESTING
//   1. rst_n=0 for 2 edges, a=8'd5, b=8'd3 -> sum=0. Release; next edge -> sum=9'd8.
//   2. Sweep a,b = 0..7 (64 pairs), 1 edge each -> sum=a+b; e.g. 7+7 -> 9'd14.
//   3. Full group-1 carry chain: a=8'hFF, b=8'h01 -> sum=9'h100.
//      Also a=8'h0F, b=8'h01 -> sum=9'h010.
//   4. Extremes: a=b=8'hFF -> sum=9'h1FE.
//      a=b=8'h80 -> sum=9'h100.
//      a=b=0 -> sum=0.
//   5. Mid-run reset: a=8'd100, b=8'd50, and sum=150.
//      Pull rst_n=0 for one edge -> sum=0.
//      Release -> sum=150 on the next edge.
//   6. Exhaustive 65536-pair or 10k random sweep, one edge per pair.
//      Check sum against a+b (9-bit) one cycle later; zero mismatches.

Source files
------------

// File: rtl/cla_8bit_adder.sv
// 8-bit unsigned two-level carry-lookahead adder with a registered 9-bit result.
// Bit P/G feed two 4-bit lookahead groups; group carries come only from group G/P.
module cla_8bit_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned NGROUP = WIDTH / GROUP;

  if (WIDTH != 8 || GROUP != 4) begin : g_bad_params
    $error("cla_8bit_adder supports only WIDTH=8, GROUP=4");
  end

  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  c;
  logic [WIDTH-1:0]  s;
  logic [NGROUP-1:0] gg;
  logic [NGROUP-1:0] gp;
  logic [NGROUP-1:0] cg;
  logic              c8;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group lookahead: internal carries depend only on bit P/G and the group carry-in
  for (genvar k = 0; k < NGROUP; k++) begin : g_group
    localparam int unsigned B = k * GROUP;

    assign c[B]   = cg[k];
    assign c[B+1] = g[B] | (p[B] & cg[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cg[k]);

    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = p[B+3] & p[B+2] & p[B+1] & p[B];
  end

  // Second-level lookahead across the two groups
  assign cg[0] = 1'b0;
  assign cg[1] = gg[0];
  assign c8    = gg[1] | (gp[1] & gg[0]);

  assign s = p ^ c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= {c8, s};
    end
  end

endmodule

// File: tb/tb_cla_8bit_adder.sv
// Scoreboard bench for cla_8bit_adder: stimulus pushes expected results,
// a monitor pops and compares one result per clock edge.
module tb_cla_8bit_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] sum;

  typedef struct packed {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;

  cla_8bit_adder #(.WIDTH(8), .GROUP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sum  (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic r, input logic [7:0] x, input logic [7:0] y);
    int unsigned total;
    total = int'(x) + int'(y);
    return r ? 9'(total) : 9'd0;
  endfunction

  // Drive one cycle of inputs well clear of the edge, record the expected result
  task automatic step(input logic r, input logic [7:0] x, input logic [7:0] y);
    item_t it;
    rst_n = r;
    a     = x;
    b     = y;
    it.rst = r;
    it.a   = x;
    it.b   = y;
    it.exp = model(r, x, y);
    q.push_back(it);
    @(posedge clk);
    #2;
  endtask

  // Monitor: the register presents a new result after every rising edge
  always begin
    item_t it;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      tests++;
      if (sum !== it.exp) begin
        fails++;
        $display("FAIL sum rst_n=%0b a=%0d b=%0d: got %0d (%b) expected %0d",
                 it.rst, it.a, it.b, sum, sum, it.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;

    step(1'b0, 8'd5, 8'd3);
    step(1'b0, 8'd5, 8'd3);
    step(1'b1, 8'd5, 8'd3);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        step(1'b1, 8'(i), 8'(j));
      end
    end

    step(1'b1, 8'hFF, 8'h01);
    step(1'b1, 8'h0F, 8'h01);
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b1, 8'h80, 8'h80);
    step(1'b1, 8'h00, 8'h00);
    step(1'b1, 8'hF0, 8'h10);
    step(1'b1, 8'hAA, 8'h55);

    step(1'b1, 8'd100, 8'd50);
    step(1'b0, 8'd100, 8'd50);
    step(1'b1, 8'd100, 8'd50);

    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 199) != 0), 8'($urandom), 8'($urandom));
    end

    // Every issued item should have been consumed by the monitor within a cycle
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
